// File: rtl/rf_seq_pkg.sv
// Shared types and widths for the RegisterFile write sequencer.
package rf_seq_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Arbitrates ALU writeback (A) and load unit (B) onto the RegisterFile write
// port, sequencing each write as setup -> strobe -> hold.
module regfile_write_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = RF_ADDR_W,
  parameter int unsigned DATA_W        = RF_DATA_W,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              write,
  output logic [ADDR_W-1:0] register_no,
  output logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              last_grant
);

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_d;
  logic [ADDR_W-1:0] register_no_d;
  logic [DATA_W-1:0] reg_data_d;
  logic              last_grant_d;
  logic [1:0]        grant;
  logic              idle;

  rr_arbiter2 u_arb (
    .valid      ({b_valid, a_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle    = (state_q == IDLE);
  assign a_ready = idle && !reset && grant[0];
  assign b_ready = idle && !reset && grant[1];
  assign busy    = !idle;

  // write is registered: it is computed one state ahead so the strobe
  // coincides exactly with the STROBE state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = 1'b0;
    register_no_d = register_no;
    reg_data_d    = reg_data;
    last_grant_d  = last_grant;
    case (state_q)
      IDLE: begin
        if (a_ready) begin
          register_no_d = a_reg;
          reg_data_d    = a_data;
          last_grant_d  = 1'b0;
          state_d       = SETUP;
        end else if (b_ready) begin
          register_no_d = b_reg;
          reg_data_d    = b_data;
          last_grant_d  = 1'b1;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        write_d = 1'b1;
        cnt_d   = CNT_INIT;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          write_d = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write       <= 1'b0;
      register_no <= '0;
      reg_data    <= '0;
      last_grant  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write       <= write_d;
      register_no <= register_no_d;
      reg_data    <= reg_data_d;
      last_grant  <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer (STROBE_CYCLES = 1 and 3).
module tb_regfile_write_sequencer;

  logic        clk;
  logic        reset;
  logic        a_valid [2];
  logic        a_ready [2];
  logic [4:0]  a_reg   [2];
  logic [31:0] a_data  [2];
  logic        b_valid [2];
  logic        b_ready [2];
  logic [4:0]  b_reg   [2];
  logic [31:0] b_data  [2];
  logic        write   [2];
  logic [4:0]  register_no [2];
  logic [31:0] reg_data [2];
  logic        busy    [2];
  logic        last_grant [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   done = 0;
  logic [31:0] rf0 [32];
  bit   acc_side [$];
  int   acc_cyc  [$];

  regfile_write_sequencer #(.STROBE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_reg(a_reg[0]), .a_data(a_data[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_reg(b_reg[0]), .b_data(b_data[0]),
    .write(write[0]), .register_no(register_no[0]), .reg_data(reg_data[0]),
    .busy(busy[0]), .last_grant(last_grant[0])
  );

  regfile_write_sequencer #(.STROBE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_reg(a_reg[1]), .a_data(a_data[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_reg(b_reg[1]), .b_data(b_data[1]),
    .write(write[1]), .register_no(register_no[1]), .reg_data(reg_data[1]),
    .busy(busy[1]), .last_grant(last_grant[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RegisterFile stand-in behind the STROBE_CYCLES=1 instance
  always @(posedge clk) if (write[0] === 1'b1) rf0[register_no[0]] <= reg_data[0];

  always @(negedge clk) begin
    if (!reset && a_valid[0] && a_ready[0]) begin acc_side.push_back(1'b0); acc_cyc.push_back(cyc); end
    if (!reset && b_valid[0] && b_ready[0]) begin acc_side.push_back(1'b1); acc_cyc.push_back(cyc); end
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_sb
    localparam int S = (gi == 0) ? 1 : 3;
    logic [36:0] q [$];
    int          m_left = 0;
    bit          m_last = 1'b1;
    logic [4:0]  cur_r = '0;
    logic [31:0] cur_d = '0;
    bit          prev_rst = 1'b0;
    bit          exp_a, exp_b;
    bit          prev_w = 1'b0;
    bit          fin = 1'b0;
    logic [36:0] e;

    // Reference model: a busy countdown of S+2 cycles after each accept,
    // with round-robin preference for whoever was not served last.
    always @(negedge clk) begin
      if (reset) begin
        check($sformatf("ready_in_reset[%0d]", gi), {a_ready[gi], b_ready[gi]}, 2'b00);
        if (prev_rst) begin
          check($sformatf("write_after_reset[%0d]", gi), write[gi], 1'b0);
          check($sformatf("busy_after_reset[%0d]", gi), busy[gi], 1'b0);
          check($sformatf("regno_after_reset[%0d]", gi), register_no[gi], 5'd0);
          check($sformatf("data_after_reset[%0d]", gi), reg_data[gi], 32'd0);
          check($sformatf("lastgrant_after_reset[%0d]", gi), last_grant[gi], 1'b1);
        end
        m_left = 0; m_last = 1'b1; cur_r = '0; cur_d = '0;
        q.delete();
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        check($sformatf("register_no[%0d]", gi), register_no[gi], cur_r);
        check($sformatf("reg_data[%0d]", gi), reg_data[gi], cur_d);
        check($sformatf("last_grant[%0d]", gi), last_grant[gi], m_last);
        if (m_left > 0) begin
          check($sformatf("busy[%0d]", gi), busy[gi], 1'b1);
          check($sformatf("write[%0d]", gi), write[gi], (m_left >= 2 && m_left <= S + 1));
          check($sformatf("ready_busy[%0d]", gi), {a_ready[gi], b_ready[gi]}, 2'b00);
          m_left--;
        end else begin
          exp_a = a_valid[gi] && (!b_valid[gi] || m_last);
          exp_b = b_valid[gi] && (!a_valid[gi] || !m_last);
          check($sformatf("busy_idle[%0d]", gi), busy[gi], 1'b0);
          check($sformatf("write_idle[%0d]", gi), write[gi], 1'b0);
          check($sformatf("ready_idle[%0d]", gi), {a_ready[gi], b_ready[gi]}, {exp_a, exp_b});
          if (exp_a) begin
            q.push_back({a_reg[gi], a_data[gi]});
            cur_r = a_reg[gi]; cur_d = a_data[gi]; m_last = 1'b0; m_left = S + 2;
          end else if (exp_b) begin
            q.push_back({b_reg[gi], b_data[gi]});
            cur_r = b_reg[gi]; cur_d = b_data[gi]; m_last = 1'b1; m_left = S + 2;
          end
        end
      end
    end

    // Monitor: every write pulse must carry the next accepted request
    always @(negedge clk) begin
      if (reset) begin
        prev_w = 1'b0;
      end else begin
        if (write[gi] && !prev_w) begin
          check($sformatf("pulse_expected[%0d]", gi), q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("pulse_reg[%0d]", gi), register_no[gi], e[36:32]);
            check($sformatf("pulse_data[%0d]", gi), reg_data[gi], e[31:0]);
          end
        end
        prev_w = write[gi];
      end
      if (done && !fin) begin
        fin = 1'b1;
        check($sformatf("pending_writes[%0d]", gi), q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int inst, input bit side, input logic [4:0] r, input logic [31:0] d,
                     input int max_wait, output bit got);
    int n;
    got = 1'b0;
    n = 0;
    if (!side) begin a_valid[inst] = 1'b1; a_reg[inst] = r; a_data[inst] = d; end
    else begin b_valid[inst] = 1'b1; b_reg[inst] = r; b_data[inst] = d; end
    while (!got && n < max_wait) begin
      @(negedge clk);
      if ((side ? b_ready[inst] : a_ready[inst]) === 1'b1) got = 1'b1;
      n++;
    end
    tick();
    if (!side) a_valid[inst] = 1'b0;
    else b_valid[inst] = 1'b0;
  endtask

  task automatic rand_stream(input int inst, input bit side, input int n);
    bit g;
    int mw;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      mw = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 100;
      req(inst, side, 5'($urandom_range(0, 31)), $urandom, mw, g);
    end
  endtask

  task automatic check_order(input string name, input int n);
    check({name, "_count"}, acc_side.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acc_side.size()) check($sformatf("%s_side%0d", name, i), acc_side[i], i % 2);
      if (i > 0 && i < acc_cyc.size()) check($sformatf("%s_gap%0d", name, i), acc_cyc[i] - acc_cyc[i-1], 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit g1, g2;
    int cnt;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 0; a_reg[i] = '0; a_data[i] = '0;
      b_valid[i] = 0; b_reg[i] = '0; b_data[i] = '0;
    end
    for (int i = 0; i < 32; i++) rf0[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_regno", register_no[i], 5'd0);
      check("reset_data", reg_data[i], 32'd0);
      check("reset_lastgrant", last_grant[i], 1'b1);
      check("reset_busy", busy[i], 1'b0);
      check("reset_write", write[i], 1'b0);
    end
    tick();

    // A alone
    req(0, 1'b0, 5'd1, 32'h39CE739E, 50, g1);
    check("t1_accept", g1, 1'b1);
    repeat (6) tick();
    check("t1_rf1", rf0[1], 32'h39CE739E);

    // A and B together straight after reset
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    acc_side.delete(); acc_cyc.delete();
    fork
      req(0, 1'b0, 5'd2, 32'h2222_0002, 50, g1);
      req(0, 1'b1, 5'd3, 32'h3333_0003, 50, g2);
    join
    repeat (6) tick();
    check("t2_accept_a", g1, 1'b1);
    check("t2_accept_b", g2, 1'b1);
    check_order("t2", 2);
    check("t2_lastgrant", last_grant[0], 1'b1);
    check("t2_rf2", rf0[2], 32'h2222_0002);
    check("t2_rf3", rf0[3], 32'h3333_0003);

    // Both valid continuously for six accepts
    acc_side.delete(); acc_cyc.delete();
    fork
      begin
        bit g;
        for (int i = 0; i < 3; i++) begin
          req(0, 1'b0, 5'($urandom_range(0, 31)), $urandom, 50, g);
          check("t3_accept_a", g, 1'b1);
        end
      end
      begin
        bit g;
        for (int i = 0; i < 3; i++) begin
          req(0, 1'b1, 5'($urandom_range(0, 31)), $urandom, 50, g);
          check("t3_accept_b", g, 1'b1);
        end
      end
    join
    repeat (6) tick();
    check_order("t3", 6);

    // Reset during STROBE
    req(0, 1'b1, 5'd4, 32'hC000_0000, 50, g1);
    check("t4_accept", g1, 1'b1);
    tick();
    reset = 1'b1;
    a_valid[0] = 1'b1;
    @(negedge clk);
    check("t4_in_strobe", write[0], 1'b1);
    check("t4_ready_a", a_ready[0], 1'b0);
    tick();
    @(negedge clk);
    check("t4_write_off", write[0], 1'b0);
    check("t4_busy_off", busy[0], 1'b0);
    check("t4_ready_a_held", a_ready[0], 1'b0);
    tick();
    reset = 1'b0;
    a_valid[0] = 1'b0;
    tick();

    // Three-cycle strobe instance
    req(1, 1'b0, 5'd7, 32'h7777_1234, 50, g1);
    check("t5_accept", g1, 1'b1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (write[1] === 1'b1) cnt++;
    end
    check("t5_strobe_len", cnt, 3);
    tick();

    // Valid from B drops while A is being written
    req(0, 1'b0, 5'd5, 32'h5555_AAAA, 50, g1);
    req(0, 1'b1, 5'd6, 32'h6666_BBBB, 2, g2);
    check("t6_accept_a", g1, 1'b1);
    check("t6_b_not_accepted", g2, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("t6_busy_done", busy[0], 1'b0);
    check("t6_rf6_untouched", rf0[6], 32'd0);
    check("t6_rf5", rf0[5], 32'h5555_AAAA);
    tick();

    fork
      rand_stream(0, 1'b0, 40);
      rand_stream(0, 1'b1, 40);
      rand_stream(1, 1'b0, 40);
      rand_stream(1, 1'b1, 40);
    join
    repeat (10) tick();
    done = 1'b1;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
